// File: rtl/reg_wr_arb_rr_if.sv
// Bundle between several write requesters and the round-robin
// arbiter that feeds one enable-gated shared register.
interface reg_wr_arb_rr_if #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [REQ_NUM-1:0]            i_req;
  logic [REQ_NUM-1:0]            i_last;
  logic [REQ_NUM*DATA_WIDTH-1:0] i_data;
  logic [REQ_NUM-1:0]            o_gnt;
  logic                          o_en;
  logic [DATA_WIDTH-1:0]         o_data;
  logic                          o_busy;
  logic [$clog2(REQ_NUM)-1:0]    o_owner;

  modport master (
    output i_req, i_last, i_data,
    input  o_gnt, o_en, o_data, o_busy, o_owner
  );

  modport slave (
    input  i_req, i_last, i_data,
    output o_gnt, o_en, o_data, o_busy, o_owner
  );
endinterface

// File: rtl/reg_wr_arb_rr.sv
// Round-robin burst write arbiter in front of one shared register.
// One IDLE cycle separates bursts; priority rotates past last owner.
module reg_wr_arb_rr #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  reg_wr_arb_rr_if.slave bus
);
  localparam int OW = $clog2(REQ_NUM);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [OW-1:0] r_owner;
  logic [CW-1:0] r_cnt;

  logic [OW-1:0] w_win;
  logic          w_any;
  logic          w_busy;
  logic          w_req;
  logic          w_beat;
  logic          w_end;

  // Search starts just above the last owner and wraps around.
  always_comb begin
    w_win = r_owner;
    w_any = 1'b0;
    for (int i = 1; i <= REQ_NUM; i++) begin
      int k;
      k = (int'(r_owner) + i) % REQ_NUM;
      if (!w_any && bus.i_req[k]) begin
        w_win = k[OW-1:0];
        w_any = 1'b1;
      end
    end
  end

  assign w_busy = (r_state == S_BUSY);
  assign w_req  = bus.i_req[r_owner];
  assign w_beat = w_busy && w_req;
  assign w_end  = w_busy && (!w_req
                  || bus.i_last[r_owner]
                  || r_cnt == CW'(MAX_BURST - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_owner <= OW'(REQ_NUM - 1);
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_beat)
            r_cnt <= r_cnt + 1'b1;
          if (w_end)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_gnt   = w_busy ? (REQ_NUM'(1) << r_owner) : '0;
  assign bus.o_en    = w_beat;
  assign bus.o_data  = w_beat
    ? bus.i_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH]
    : '0;
  assign bus.o_busy  = w_busy;
  assign bus.o_owner = r_owner;
endmodule

// File: tb/tb_reg_wr_arb_rr.sv
// Bench for reg_wr_arb_rr: vector tables, corner sequences and
// random traffic against a burst-level reference model.
module tb_reg_wr_arb_rr;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_wr_arb_rr_if #(.REQ_NUM(N), .DATA_WIDTH(DW)) bus ();

  reg_wr_arb_rr #(
    .REQ_NUM(N), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  bit m_busy;
  int m_own;
  int m_left;

  typedef struct {
    bit                rst_first;
    logic [N-1:0]      req;
    logic [N-1:0]      last;
    logic [N*DW-1:0]   data;
    logic [N-1:0]      gnt;
    logic              en;
    logic [DW-1:0]     dout;
    logic              busy;
    int                own;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] pack(
    logic [DW-1:0] d0, logic [DW-1:0] d1,
    logic [DW-1:0] d2, logic [DW-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic int pick(logic [N-1:0] req, int last);
    for (int s = 1; s <= N; s++)
      if (req[(last + s) % N]) return (last + s) % N;
    return -1;
  endfunction

  function automatic vec_t mk(
    bit r, logic [N-1:0] req, logic [N-1:0] last,
    logic [N*DW-1:0] data, logic [N-1:0] gnt, logic en,
    logic [DW-1:0] dout, logic busy, int own);
    vec_t v;
    v.rst_first = r; v.req = req; v.last = last; v.data = data;
    v.gnt = gnt; v.en = en; v.dout = dout; v.busy = busy;
    v.own = own;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_own  = N - 1;
    m_left = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_req = '0; bus.i_last = '0; bus.i_data = '0;
    #1;
    chk("rst_gnt",   64'(bus.o_gnt),   64'(0));
    chk("rst_en",    64'(bus.o_en),    64'(0));
    chk("rst_data",  64'(bus.o_data),  64'(0));
    chk("rst_busy",  64'(bus.o_busy),  64'(0));
    chk("rst_owner", 64'(bus.o_owner), 64'(N - 1));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive, compare against model, advance model.
  task automatic cyc(logic [N-1:0] req, logic [N-1:0] last,
                     logic [N*DW-1:0] data);
    logic [N-1:0]  e_gnt;
    logic          e_en;
    logic [DW-1:0] e_data;
    @(negedge clk);
    bus.i_req = req; bus.i_last = last; bus.i_data = data;
    #1;
    e_gnt  = m_busy ? (N'(1) << m_own) : '0;
    e_en   = m_busy && req[m_own];
    e_data = e_en ? data[m_own*DW +: DW] : '0;
    chk("gnt",    64'(bus.o_gnt),   64'(e_gnt));
    chk("en",     64'(bus.o_en),    64'(e_en));
    chk("data",   64'(bus.o_data),  64'(e_data));
    chk("busy",   64'(bus.o_busy),  64'(m_busy));
    chk("owner",  64'(bus.o_owner), 64'(m_own));
    chk("onehot", 64'($onehot0(bus.o_gnt)), 64'(1));
    if (!m_busy) begin
      int w;
      w = pick(req, m_own);
      if (w >= 0) begin
        m_own = w; m_busy = 1'b1; m_left = MB;
      end
    end else if (!req[m_own]) begin
      m_busy = 1'b0;
    end else begin
      m_left--;
      if (last[m_own] || m_left == 0) m_busy = 1'b0;
    end
  endtask

  initial begin
    logic [N*DW-1:0] da, db, dd;
    int en_cnt;

    rst = 1'b1;
    bus.i_req = '0; bus.i_last = '0; bus.i_data = '0;
    model_reset();

    da = pack(32'h0A0A0A0A, 32'h1B1B1B1B,
              32'hFFFF00FF, 32'h3C3C3C3C);
    db = pack(32'hA0000000, 32'hA1000001,
              32'hA2000002, 32'hA3000003);

    // single requester: 4-beat burst, gap, regrant
    tbl.push_back(mk(1, 4'b0100, 0, da, 4'b0000, 0, 0, 0, 3));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 4'b0100, 0, da, 4'b0100, 1,
                       32'hFFFF00FF, 1, 2));
    tbl.push_back(mk(0, 4'b0100, 0, da, 4'b0000, 0, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0100, 0, da, 4'b0100, 1,
                     32'hFFFF00FF, 1, 2));
    // strict rotation with last on every beat
    tbl.push_back(mk(1, 4'b1111, 4'b1111, db, 4'b0000, 0, 0, 0, 3));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(0, 4'b1111, 4'b1111, db,
                       4'(1 << (k % 4)), 1,
                       db[(k % 4)*DW +: DW], 1, k % 4));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, db, 4'b0000, 0, 0, 0,
                       k % 4));
    end

    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset();
      cyc(tbl[i].req, tbl[i].last, tbl[i].data);
      chk("tv_gnt",   64'(bus.o_gnt),   64'(tbl[i].gnt));
      chk("tv_en",    64'(bus.o_en),    64'(tbl[i].en));
      chk("tv_data",  64'(bus.o_data),  64'(tbl[i].dout));
      chk("tv_busy",  64'(bus.o_busy),  64'(tbl[i].busy));
      chk("tv_owner", 64'(bus.o_owner), 64'(tbl[i].own));
    end

    // early last from owner 1, then next requester above 1
    do_reset();
    en_cnt = 0;
    cyc(4'b0010, 0, pack(0, 1, 0, 0));
    en_cnt += int'(bus.o_en);
    cyc(4'b0010, 0, pack(0, 1, 0, 0));
    en_cnt += int'(bus.o_en);
    chk("el_d1", 64'(bus.o_data), 64'(32'h1));
    cyc(4'b1011, 4'b0010, pack(0, 2, 0, 0));
    en_cnt += int'(bus.o_en);
    chk("el_d2", 64'(bus.o_data), 64'(32'h2));
    cyc(4'b1001, 0, pack(0, 2, 0, 0));
    en_cnt += int'(bus.o_en);
    chk("el_idle", 64'(bus.o_busy), 64'(0));
    cyc(4'b1001, 0, pack(0, 2, 0, 0));
    chk("el_next", 64'(bus.o_gnt), 64'(4'b1000));
    chk("el_pulses", 64'(en_cnt), 64'(2));

    // abort: owner 0 drops request after one beat
    do_reset();
    cyc(4'b1001, 0, db);
    cyc(4'b1001, 0, db);
    chk("ab_beat", 64'(bus.o_en), 64'(1));
    cyc(4'b1000, 0, db);
    chk("ab_drop_en", 64'(bus.o_en), 64'(0));
    cyc(4'b1000, 0, db);
    chk("ab_idle", 64'(bus.o_busy), 64'(0));
    cyc(4'b1000, 0, db);
    chk("ab_gnt3", 64'(bus.o_gnt), 64'(4'b1000));

    // async reset during owner 2's second beat
    do_reset();
    cyc(4'b0100, 0, da);
    cyc(4'b0100, 0, da);
    cyc(4'b0100, 0, da);
    chk("ar_beat2", 64'(bus.o_en), 64'(1));
    #2;
    rst = 1'b1;
    bus.i_req = '0;
    #1;
    chk("ar_gnt",  64'(bus.o_gnt),  64'(0));
    chk("ar_en",   64'(bus.o_en),   64'(0));
    chk("ar_busy", 64'(bus.o_busy), 64'(0));
    chk("ar_own",  64'(bus.o_owner), 64'(N - 1));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b1100, 0, da);
    cyc(4'b1100, 0, da);
    chk("ar_first", 64'(bus.o_gnt), 64'(4'b0100));

    // non-owner isolation while owner 0 bursts
    do_reset();
    dd = pack(32'h12345678, 32'hFFFFFFFF, 0, 0);
    cyc(4'b0001, 0, dd);
    for (int i = 0; i < 4; i++) begin
      cyc({2'b00, 1'(i % 2), 1'b1}, 4'b0010, dd);
      chk("iso_data", 64'(bus.o_data == 32'hFFFFFFFF), 64'(0));
      chk("iso_gnt",  64'(bus.o_gnt), 64'(4'b0001));
    end
    cyc(4'b0011, 0, dd);
    cyc(4'b0011, 0, dd);
    chk("iso_gnt1", 64'(bus.o_gnt),  64'(4'b0010));
    chk("iso_d1",   64'(bus.o_data), 64'(32'hFFFFFFFF));

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0]    rq, ls;
      logic [N*DW-1:0] rd;
      rq = 4'($urandom);
      ls = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      for (int k = 0; k < N; k++) rd[k*DW +: DW] = $urandom;
      cyc(rq, ls, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_wr_arb_rr.md
Name: reg_wr_arb_rr

Overview:
Round-robin write arbiter that shares one enable-gated data register among REQ_NUM requesters. It drives the register's i_en/i_data pair from a single granted requester at a time. Each grant is a burst of beats. A burst ends on the requester's last flag, when the beat limit is reached, or when the requester drops its request. The block sits directly in front of the shared register inside datapath blocks that need several writers.

Parameters:
REQ_NUM, 4, number of requesters (2..16)
DATA_WIDTH, 32, width of each requester's data word and of o_data
MAX_BURST, 4, maximum beats per grant (1..255)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  asynchronous reset, active-high
i_req  input  REQ_NUM  per-requester write request, bit k = requester k
i_last  input  REQ_NUM  per-requester last-beat flag, sampled only with a transferring beat
i_data  input  REQ_NUM*DATA_WIDTH  requester k data in bits [k*DATA_WIDTH +: DATA_WIDTH]
o_gnt  output  REQ_NUM  one-hot grant, all-zero when idle
o_en  output  1  write enable to shared register
o_data  output  DATA_WIDTH  write data to shared register
o_busy  output  1  high while a burst owner exists
o_owner  output  $clog2(REQ_NUM)  index of current or last owner

Behaviour:
- Reset (async, i_rst=1): state=IDLE; o_gnt=0; o_busy=0; beat_cnt=0; last_owner=REQ_NUM-1, so requester 0 has first priority; o_owner=REQ_NUM-1.
- While IDLE: o_en=0 and o_data=0.
- States: IDLE, BUSY.
- IDLE:
  - If i_req != 0, select a winner by rotating priority. The search starts at (last_owner+1) mod REQ_NUM and ascends with wrap-around.
  - Next edge: owner=winner, last_owner=winner, beat_cnt=0, state=BUSY.
  - If i_req == 0, remain in IDLE.
- BUSY:
  - o_gnt=onehot(owner), o_busy=1, o_owner=owner.
  - Beat: a beat is transferred in a cycle where i_req[owner]=1. In that cycle o_en=1 and o_data=i_data slice of owner. Both are combinational from the registered owner, so the register captures the word on the same edge.
  - beat_cnt increments per beat.
  - Burst end: the burst ends at the edge after any of the following. The next state is IDLE, giving a fixed 1-cycle arbitration gap.
    - (a) a beat with i_last[owner]=1;
    - (b) a beat where beat_cnt == MAX_BURST-1, i.e. the MAX_BURST-th beat;
    - (c) i_req[owner]=0 (abort; o_en=0 that cycle, no beat).
- Requests from non-owners never produce o_en and never disturb the burst. They are held off until the next IDLE arbitration.
- i_last on a non-owner or non-beat cycle is ignored.
- MAX_BURST=1: every grant is exactly one beat.
- Fairness: after requester k owns a burst, k has lowest priority in the next arbitration. A continuously requesting set of M requesters is served in strict rotation.
- o_en is never asserted for two different requesters on one cycle. o_gnt is always zero or one-hot.
- Reset asserted mid-burst: immediate return to reset values; the in-flight beat is dropped, with no o_en after i_rst rises. Priority restarts at requester 0.
- beat_cnt width is $clog2(MAX_BURST+1) and it never wraps (the burst ends first).
- o_owner holds last_owner while IDLE.

Test Plan:
- Reset then single requester: i_req=4'b0100, i_data[2]=32'hFFFF00FF, i_last=0 → IDLE 1 cycle, then o_gnt=4'b0100, o_en=1 for 4 cycles with o_data=32'hFFFF00FF, burst ends on MAX_BURST, 1 idle cycle, regrant to requester 2.
- Rotation: i_req=4'b1111 held, i_last=4'b1111 → owners 0,1,2,3,0 in order, each one beat, each separated by one IDLE cycle; o_gnt always one-hot.
- Early last: owner 1 sends beats 32'h00000001, 32'h00000002 with i_last[1]=1 on the second → exactly 2 o_en pulses, then IDLE, next grant goes to the next requester above 1 that is requesting.
- Abort: owner 0 drops i_req[0] after 1 beat while i_req[3]=1 → o_en low in the drop cycle, IDLE next, then o_gnt=4'b1000.
- Async reset mid-burst: assert i_rst between edges during owner 2's second beat → o_gnt=0, o_en=0, o_busy=0 immediately. After release with i_req=4'b1100, the first grant goes to requester 2.
- Non-owner isolation: owner 0 bursting, requester 1 toggles i_req/i_data=32'hFFFFFFFF → o_data never equals requester 1's data until requester 1 is granted.
